arm_mc_controller: RTL and testbench

- Multicycle control unit for the ARM datapath.
- Sequences fetch/decode/execute over a shared memory and a single ALU.
- Generates all datapath selects, including the 2-bit ImmSrc code consumed by the immediate extender.
- Holds the NZCV flags register and gates architectural writes with the condition check.

---
 rtl/arm_ctrl_pkg.sv | 82 ++++++++
 rtl/arm_cond_unit.sv | 65 ++++++
 rtl/arm_mc_controller.sv | 141 ++++++++++++++
 tb/tb_arm_mc_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings for the multicycle ARM control unit.
//   state_t      - controller FSM states
//   ALU_*        - ALUControl codes
//   IMM_*        - ImmSrc codes for the immediate extender
//   OP_*         - Instr[27:26] instruction classes
//   CMD_*        - data-processing cmd field values
//   COND_*       - Instr[31:28] condition encodings
//   cond_holds() - condition evaluator against an NZCV value
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    // AL (1110) and the unused 1111 encoding both fall to the default: always.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_holds = z;
            COND_NE: cond_holds = ~z;
            COND_CS: cond_holds = c;
            COND_CC: cond_holds = ~c;
            COND_MI: cond_holds = n;
            COND_PL: cond_holds = ~n;
            COND_VS: cond_holds = v;
            COND_VC: cond_holds = ~v;
            COND_HI: cond_holds = c & ~z;
            COND_LS: cond_holds = ~c | z;
            COND_GE: cond_holds = n == v;
            COND_LT: cond_holds = n != v;
            COND_GT: cond_holds = ~z & (n == v);
            COND_LE: cond_holds = z | (n != v);
            default: cond_holds = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// arm_cond_unit: NZCV register, condition check latch and write-enable gating.
//   clk, reset      - clock, async active-high reset
//   cond_i          - instruction condition field
//   alu_flags_i     - NZCV produced by the ALU this cycle
//   latch_i         - capture the condition result this cycle (DECODE)
//   flag_w_i        - flag-setting execute cycle (N/Z update)
//   cv_w_i          - C/V also update (ADD/SUB/CMP)
//   next_pc_i, branch_i, reg_w_i, mem_w_i - raw enables from the FSM
//   rd_pc_i         - destination register is R15
//   flags_o         - current NZCV register
//   pc_write_o, reg_write_o, mem_write_o  - gated enables, 0 during reset
module arm_cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       latch_i,
    input  logic       flag_w_i,
    input  logic       cv_w_i,
    input  logic       next_pc_i,
    input  logic       branch_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       rd_pc_i,
    output logic [3:0] flags_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       pcs;

    // The condition is judged once, against the flags as they stand in DECODE;
    // the execute-stage flag update must not retroactively change it.
    always_comb begin
        flags_d   = (flag_w_i && cond_ex_q)
                  ? {alu_flags_i[3:2], cv_w_i ? alu_flags_i[1:0] : flags_q[1:0]}
                  : flags_q;
        cond_ex_d = latch_i ? cond_holds(cond_i, flags_q) : cond_ex_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // A write to R15 is a PC write, not a register-file write.
    assign pcs         = branch_i | (rd_pc_i & reg_w_i);
    assign pc_write_o  = ~reset & (next_pc_i | (pcs & cond_ex_q));
    assign reg_write_o = ~reset & reg_w_i & ~pcs & cond_ex_q;
    assign mem_write_o = ~reset & mem_w_i & cond_ex_q;
    assign flags_o     = flags_q;

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control unit (fetch/decode/execute FSM).
//   clk, reset          - clock, async active-high reset
//   Cond, Op, Funct, Rd - instruction fields from the instruction register
//   ALUFlags            - NZCV from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite - write enables, 0 during reset
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc - selects
//   Flags               - current NZCV register
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [3:0] Flags
);

    state_t     state_q, state_d;
    logic       irw, next_pc, reg_w, mem_w, branch, alu_op;
    logic [3:0] cmd;

    assign cmd = Funct[4:1];

    always_comb begin
        state_d   = S_FETCH;
        irw       = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                irw       = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = Op == OP_MEM ? S_MEMADR
                          : Op == OP_BR  ? S_BRANCH
                          : Op == OP_DP  ? (Funct[5] ? S_EXECI : S_EXECR)
                          : S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: reg_w = cmd != CMD_CMP;
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign ALUControl = !alu_op                          ? ALU_ADD
                      : cmd == CMD_SUB || cmd == CMD_CMP ? ALU_SUB
                      : cmd == CMD_AND                   ? ALU_AND
                      : cmd == CMD_ORR                   ? ALU_ORR
                      : ALU_ADD;

    // The extender format follows the instruction class one-to-one.
    assign ImmSrc  = Op == OP_DP ? IMM_8 : Op == OP_MEM ? IMM_12 : Op == OP_BR ? IMM_24 : Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BR};
    assign IRWrite = irw & ~reset;

    arm_cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond_i     (Cond),
        .alu_flags_i(ALUFlags),
        .latch_i    (state_q == S_DECODE),
        .flag_w_i   ((state_q == S_EXECR || state_q == S_EXECI) && Funct[0]),
        .cv_w_i     (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP),
        .next_pc_i  (next_pc),
        .branch_i   (branch),
        .reg_w_i    (reg_w),
        .mem_w_i    (mem_w),
        .rd_pc_i    (Rd == 4'hF),
        .flags_o    (Flags),
        .pc_write_o (PCWrite),
        .reg_write_o(RegWrite),
        .mem_write_o(MemWrite)
    );

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: scoreboard bench for the multicycle ARM controller.
module tb_arm_mc_controller;

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'hE, Rd = 4'h0, ALUFlags = 4'h0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc;
    logic [3:0] Flags;
    logic [20:0] obs;

    logic [20:0] exp_q[$];
    string       nm_q[$];
    logic [3:0]  fl_m = 4'b0000;
    int          tests = 0;
    int          failures = 0;

    arm_mc_controller #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .Flags(Flags)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ResultSrc, ImmSrc, Flags};

    // en = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}
    function automatic logic [20:0] sig(input logic [4:0] en, input logic [1:0] rs, sa, sb,
                                        alu, res, imm, input logic [3:0] fl);
        return {en, rs, sa, sb, alu, res, imm, fl};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        case (c)
            4'd0:  return f[2];
            4'd1:  return !f[2];
            4'd2:  return f[1];
            4'd3:  return !f[1];
            4'd4:  return f[3];
            4'd5:  return !f[3];
            4'd6:  return f[0];
            4'd7:  return !f[0];
            4'd8:  return f[1] && !f[2];
            4'd9:  return !f[1] || f[2];
            4'd10: return f[3] == f[0];
            4'd11: return f[3] != f[0];
            4'd12: return !f[2] && f[3] == f[0];
            4'd13: return f[2] || f[3] != f[0];
            default: return 1'b1;
        endcase
    endfunction

    task automatic push(input string nm, input logic [20:0] v);
        exp_q.push_back(v);
        nm_q.push_back(nm);
    endtask

    // Applies one instruction and queues the per-cycle outputs it must produce.
    task automatic drive(input string nm, input instr_t in);
        logic [1:0] rs, alu;
        logic [3:0] cmd;
        logic       ce, w, arith;
        {Cond, Op, Funct, Rd, ALUFlags} = in;
        rs    = {in.op == 2'b01, in.op == 2'b10};
        ce    = cond_ok(in.cond, fl_m);
        cmd   = in.funct[4:1];
        arith = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010;
        push({nm, ".fetch"}, sig(5'b10010, rs, 2'b01, 2'b10, 2'b00, 2'b10, in.op, fl_m));
        push({nm, ".decode"}, sig(5'b00000, rs, 2'b01, 2'b10, 2'b00, 2'b10, in.op, fl_m));
        case (in.op)
            2'b00: begin
                alu = cmd == 4'b0100 ? 2'b00 : (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01
                    : cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : 2'b00;
                push({nm, ".exec"}, sig(5'b00000, rs, 2'b00, in.funct[5] ? 2'b01 : 2'b00,
                                        alu, 2'b00, in.op, fl_m));
                if (in.funct[0] && ce)
                    fl_m = {in.af[3:2], arith ? in.af[1:0] : fl_m[1:0]};
                w = cmd != 4'b1010;
                push({nm, ".aluwb"}, sig({ce && w && in.rd == 4'hF, 1'b0, ce && w && in.rd != 4'hF, 2'b00},
                                         rs, 2'b00, 2'b00, 2'b00, 2'b00, in.op, fl_m));
            end
            2'b01: begin
                push({nm, ".memadr"}, sig(5'b00000, rs, 2'b00, 2'b01, 2'b00, 2'b00, in.op, fl_m));
                if (in.funct[0]) begin
                    push({nm, ".memread"}, sig(5'b00001, rs, 2'b00, 2'b00, 2'b00, 2'b00, in.op, fl_m));
                    push({nm, ".memwb"}, sig({ce && in.rd == 4'hF, 1'b0, ce && in.rd != 4'hF, 2'b00},
                                             rs, 2'b00, 2'b00, 2'b00, 2'b01, in.op, fl_m));
                end else
                    push({nm, ".memwrite"}, sig({1'b0, ce, 3'b001}, rs, 2'b00, 2'b00, 2'b00, 2'b00, in.op, fl_m));
            end
            2'b10: push({nm, ".branch"}, sig({ce, 4'b0000}, rs, 2'b10, 2'b01, 2'b00, 2'b10, in.op, fl_m));
            default: ;
        endcase
    endtask

    task automatic test_reset();
        {Cond, Op, Funct, Rd} = {4'hE, 2'b01, 6'b011001, 4'h2};
        #2;
        tests++;
        if (obs !== sig(5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000)) begin
            failures++;
            $display("FAIL reset.hold got %b expected %b", obs, sig(5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000));
        end
        @(posedge clk); #1;
        tests++;
        if (obs !== sig(5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000)) begin
            failures++;
            $display("FAIL reset.edge got %b expected %b", obs, sig(5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000));
        end
        reset = 1'b0;
        #1;
        tests++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL reset.release IRWrite=%b PCWrite=%b expected 1 1", IRWrite, PCWrite);
        end
    endtask

    task automatic test_data_processing();
        instr_t p[3] = '{instr_t'{4'hE, 2'b00, 6'b001000, 4'h1, 4'h0},
                         instr_t'{4'hF, 2'b00, 6'b111000, 4'h2, 4'h0},
                         instr_t'{4'hE, 2'b00, 6'b000000, 4'h3, 4'h0}};
        logic [20:0] e;
        string nm;
        foreach (p[i]) begin
            drive($sformatf("dp%0d", i), p[i]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
        end
        tests++;
        if (Flags !== 4'b0000) begin
            failures++;
            $display("FAIL dp.flags got %b expected 0000", Flags);
        end
    endtask

    task automatic test_memory();
        instr_t p[2] = '{instr_t'{4'hE, 2'b01, 6'b011001, 4'h2, 4'h0},
                         instr_t'{4'hE, 2'b01, 6'b011000, 4'h4, 4'h0}};
        logic [20:0] e;
        string nm;
        foreach (p[i]) begin
            drive($sformatf("mem%0d", i), p[i]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch_flags();
        instr_t p[5] = '{instr_t'{4'hE, 2'b00, 6'b000101, 4'h3, 4'b0100},
                         instr_t'{4'h0, 2'b10, 6'b100000, 4'h0, 4'h0},
                         instr_t'{4'h1, 2'b10, 6'b100000, 4'h0, 4'h0},
                         instr_t'{4'h0, 2'b00, 6'b000101, 4'h4, 4'b0001},
                         instr_t'{4'hE, 2'b00, 6'b000001, 4'h5, 4'b1110}};
        logic [3:0] want[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b1101};
        logic [20:0] e;
        string nm;
        foreach (p[i]) begin
            drive($sformatf("bf%0d", i), p[i]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
            tests++;
            if (Flags !== want[i]) begin
                failures++;
                $display("FAIL bf%0d.flags got %b expected %b", i, Flags, want[i]);
            end
        end
    endtask

    task automatic test_cmp_str();
        instr_t p[4] = '{instr_t'{4'hE, 2'b00, 6'b010101, 4'h0, 4'b1000},
                         instr_t'{4'h0, 2'b01, 6'b011000, 4'h1, 4'h0},
                         instr_t'{4'h0, 2'b00, 6'b000101, 4'h6, 4'b0100},
                         instr_t'{4'hE, 2'b00, 6'b011000, 4'h7, 4'h0}};
        logic [20:0] e;
        string nm;
        foreach (p[i]) begin
            drive($sformatf("cs%0d", i), p[i]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
            tests++;
            if (Flags !== 4'b1000) begin
                failures++;
                $display("FAIL cs%0d.flags got %b expected 1000", i, Flags);
            end
        end
    endtask

    task automatic test_pc_write_undef();
        instr_t p[2] = '{instr_t'{4'hE, 2'b00, 6'b001000, 4'hF, 4'h0},
                         instr_t'{4'hE, 2'b11, 6'b000000, 4'h0, 4'h0}};
        logic [20:0] e;
        string nm;
        foreach (p[i]) begin
            drive($sformatf("pc%0d", i), p[i]);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [20:0] r = sig(5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000);
        logic [20:0] e;
        string nm;
        {Cond, Op, Funct, Rd} = {4'hE, 2'b01, 6'b011001, 4'h2};
        @(posedge clk);
        @(posedge clk); #2;
        tests++;
        if (obs !== sig(5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, fl_m)) begin
            failures++;
            $display("FAIL areset.memadr got %b expected %b", obs, sig(5'b00000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, fl_m));
        end
        reset = 1'b1;
        #1;
        tests++;
        if (obs !== r) begin
            failures++;
            $display("FAIL areset.immediate got %b expected %b", obs, r);
        end
        @(posedge clk); #1;
        tests++;
        if (obs !== r) begin
            failures++;
            $display("FAIL areset.held got %b expected %b", obs, r);
        end
        reset = 1'b0;
        fl_m  = 4'b0000;
        #1;
        tests++;
        if (obs !== sig(5'b10010, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 4'b0000)) begin
            failures++;
            $display("FAIL areset.release got %b expected IRWrite fetch pattern", obs);
        end
        drive("post_reset", instr_t'{4'hE, 2'b00, 6'b001000, 4'h1, 4'h0});
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            nm = nm_q.pop_front();
            tests++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s got %b expected %b", nm, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        instr_t r;
        logic [20:0] e;
        string nm;
        for (int k = 0; k < 40; k++) begin
            r.cond  = 4'($urandom);
            r.op    = 2'($urandom);
            r.funct = 6'($urandom);
            r.rd    = 4'($urandom);
            r.af    = 4'($urandom);
            drive($sformatf("rand%0d", k), r);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                nm = nm_q.pop_front();
                tests++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s got %b expected %b", nm, obs, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_data_processing();
        test_memory();
        test_branch_flags();
        test_cmp_str();
        test_pc_write_undef();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
